// File: rtl/serial_add_sub.sv
// Sequential WIDTH-bit adder/subtractor that processes CHUNK bits per cycle, LSB first.
// The carry register is shared across slices, and done pulses once when s/cout/overflow are valid.
module serial_add_sub #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned NCH = WIDTH / CHUNK;
  localparam int unsigned KW  = (NCH > 1) ? $clog2(NCH) : 1;

  if (CHUNK == 0 || WIDTH < 2 || (WIDTH % CHUNK) != 0) begin : g_bad_param
    $error("serial_add_sub: WIDTH must be >= 2 and divisible by CHUNK");
  end

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] bx_q, bx_d;
  logic             carry_q, carry_d;
  logic [KW-1:0]    k_q, k_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [CHUNK-1:0] a_sl_c, b_sl_c;
  logic [CHUNK:0]   slice_sum_c;
  logic             msb_cin_c;
  logic             last_c;

  // Current slice: the low CHUNK bits of the operand shift registers.
  always_comb begin
    a_sl_c      = a_q[CHUNK-1:0];
    b_sl_c      = bx_q[CHUNK-1:0];
    slice_sum_c = {1'b0, a_sl_c} + {1'b0, b_sl_c} + {{CHUNK{1'b0}}, carry_q};
    msb_cin_c   = a_sl_c[CHUNK-1] ^ b_sl_c[CHUNK-1] ^ slice_sum_c[CHUNK-1];
    last_c      = (k_q == KW'(NCH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      bx_q    <= '0;
      carry_q <= 1'b0;
      k_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      bx_q    <= bx_d;
      carry_q <= carry_d;
      k_q     <= k_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)  state_d = RUN;
      RUN:     if (last_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs; the result shifts in from the MSB end.
  always_comb begin
    a_d     = a_q;
    bx_d    = bx_q;
    carry_d = carry_q;
    k_d     = k_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    if (state_q == IDLE && start) begin
      a_d     = a;
      bx_d    = sub ? ~b : b;
      carry_d = sub ? ~cin : cin;
      k_d     = '0;
      busy_d  = 1'b1;
    end else if (state_q == RUN) begin
      a_d     = a_q >> CHUNK;
      bx_d    = bx_q >> CHUNK;
      carry_d = slice_sum_c[CHUNK];
      s_d     = (s_q >> CHUNK) | (WIDTH'(slice_sum_c[CHUNK-1:0]) << (WIDTH - CHUNK));
      k_d     = k_q + KW'(1);
      if (last_c) begin
        cout_d = slice_sum_c[CHUNK];
        ovf_d  = msb_cin_c ^ slice_sum_c[CHUNK];
        k_d    = '0;
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign s        = s_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Bench for serial_add_sub: four instances (CHUNK = 1, 2, 4, 8) share the operand inputs.
// Expected results are queued per instance when start is driven and popped on each done.
module tb_serial_add_sub;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] start_v;
  logic [7:0] a, b;
  logic       cin, sub;
  logic [3:0] busy_w, done_w, cout_w, ovf_w;
  logic [7:0] s_w [4];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [7:0] s;
    logic       c;
    logic       o;
    int         due;
  } exp_t;

  typedef struct {
    int         idx;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] es;
    logic       ec;
    logic       eo;
  } vec_t;

  exp_t exp_q [4][$];
  vec_t vecs [9];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    serial_add_sub #(.WIDTH(8), .CHUNK(1 << g)) u_dut (
      .clk(clk), .rst(rst), .start(start_v[g]), .a(a), .b(b), .cin(cin), .sub(sub),
      .busy(busy_w[g]), .done(done_w[g]), .s(s_w[g]), .cout(cout_w[g]), .overflow(ovf_w[g])
    );
  end

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s dut%0d actual=%0h required=%0h (cycle %0d)", name, idx, act, req, cyc);
    end
  endtask

  function automatic exp_t model(input logic [7:0] ia, input logic [7:0] ib,
                                 input logic icin, input logic isub);
    exp_t       e;
    logic [7:0] bx;
    logic       c0;
    logic [8:0] r;
    bx    = isub ? ~ib : ib;
    c0    = isub ? ~icin : icin;
    r     = {1'b0, ia} + {1'b0, bx} + {8'b0, c0};
    e.s   = r[7:0];
    e.c   = r[8];
    e.o   = (ia[7] == bx[7]) && (r[7] != ia[7]);
    e.due = 0;
    return e;
  endfunction

  // Scoreboard monitor: every done must match the oldest queued expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      if (done_w[i]) begin
        if (exp_q[i].size() == 0) begin
          chk("unexpected_done", i, 32'(done_w[i]), 32'(0));
        end else begin
          e = exp_q[i].pop_front();
          chk("s", i, 32'(s_w[i]), 32'(e.s));
          chk("cout", i, 32'(cout_w[i]), 32'(e.c));
          chk("overflow", i, 32'(ovf_w[i]), 32'(e.o));
          chk("done_cycle", i, 32'(cyc), 32'(e.due));
        end
        chk("busy_with_done", i, 32'(busy_w[i]), 32'(0));
      end
    end
  end

  // Called at a negedge; returns at a negedge once the result has been checked.
  task automatic run_op(input int idx, input logic [7:0] ia, input logic [7:0] ib,
                        input logic icin, input logic isub, input exp_t e);
    int n;
    n = 8 >> idx;
    a = ia; b = ib; cin = icin; sub = isub;
    start_v[idx] = 1'b1;
    e.due = cyc + 1 + n;
    exp_q[idx].push_back(e);
    @(negedge clk);
    start_v[idx] = 1'b0;
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    wait_empty(idx);
  endtask

  task automatic wait_empty(input int idx);
    int n;
    n = 8 >> idx;
    for (int t = 0; t < 2 * n + 6 && exp_q[idx].size() != 0; t++) @(negedge clk);
    if (exp_q[idx].size() != 0) begin
      chk("done_timeout", idx, 32'(exp_q[idx].size()), 32'(0));
      exp_q[idx].delete();
    end
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    exp_t e;
    logic [7:0] ra, rb;
    logic       rc, rs;

    vecs[0] = '{0, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[1] = '{0, 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
    vecs[2] = '{0, 8'h10, 8'h01, 1'b1, 1'b1, 8'h0E, 1'b1, 1'b0};
    vecs[3] = '{2, 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0};
    vecs[4] = '{2, 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[5] = '{1, 8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0};
    vecs[6] = '{3, 8'hFF, 8'hFF, 1'b0, 1'b0, 8'hFE, 1'b1, 1'b0};
    vecs[7] = '{1, 8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[8] = '{3, 8'h7F, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1};

    rst = 1'b1; start_v = '0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("reset_busy", i, 32'(busy_w[i]), 32'(0));
      chk("reset_done", i, 32'(done_w[i]), 32'(0));
      chk("reset_s", i, 32'(s_w[i]), 32'(0));
      chk("reset_cout", i, 32'(cout_w[i]), 32'(0));
      chk("reset_ovf", i, 32'(ovf_w[i]), 32'(0));
    end
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors with hand-computed results.
    for (int v = 0; v < 9; v++) begin
      e.s = vecs[v].es; e.c = vecs[v].ec; e.o = vecs[v].eo; e.due = 0;
      run_op(vecs[v].idx, vecs[v].a, vecs[v].b, vecs[v].cin, vecs[v].sub, e);
    end

    // Start pulsed mid-run with other operands must be ignored.
    a = 8'h12; b = 8'h34; cin = 1'b0; sub = 1'b0;
    e = model(8'h12, 8'h34, 1'b0, 1'b0);
    e.due = cyc + 1 + 8;
    exp_q[0].push_back(e);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy_mid_run", 0, 32'(busy_w[0]), 32'(1));
    a = 8'hAA; b = 8'h55; cin = 1'b1; sub = 1'b1;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_empty(0);
    repeat (12) @(negedge clk);

    // Reset in the middle of an operation: no result, no done.
    a = 8'hC3; b = 8'h3C; cin = 1'b1; sub = 1'b0;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_busy", 0, 32'(busy_w[0]), 32'(0));
    chk("rst_done", 0, 32'(done_w[0]), 32'(0));
    chk("rst_s", 0, 32'(s_w[0]), 32'(0));
    rst = 1'b0;
    repeat (12) @(negedge clk);
    run_op(0, 8'h21, 8'h43, 1'b1, 1'b0, model(8'h21, 8'h43, 1'b1, 1'b0));

    // Back-to-back: start held high across the done cycle.
    for (int idx = 0; idx < 4; idx += 2) begin
      a = 8'h9C; b = 8'h47; cin = 1'b0; sub = 1'b1;
      e = model(8'h9C, 8'h47, 1'b0, 1'b1);
      e.due = cyc + 1 + (8 >> idx);
      exp_q[idx].push_back(e);
      start_v[idx] = 1'b1;
      @(negedge clk);
      a = 8'h66; b = 8'h2B; cin = 1'b1; sub = 1'b0;
      e = model(8'h66, 8'h2B, 1'b1, 1'b0);
      e.due = cyc + 2 * (8 >> idx) + 1;
      exp_q[idx].push_back(e);
      repeat ((8 >> idx) + 1) @(negedge clk);
      start_v[idx] = 1'b0;
      a = 8'h00; b = 8'hFF;
      wait_empty(idx);
    end

    // Random operations on every chunk size against the reference model.
    for (int idx = 0; idx < 4; idx++) begin
      for (int r = 0; r < 40; r++) begin
        ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom); rs = 1'($urandom);
        run_op(idx, ra, rb, rc, rs, model(ra, rb, rc, rs));
      end
    end

    repeat (12) @(negedge clk);
    for (int i = 0; i < 4; i++) chk("queue_drained", i, 32'(exp_q[i].size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
